// File: rtl/bomb_manager_if.sv
// bomb_manager_if: placement request/response and explosion-event valid/ready bundle.
interface bomb_manager_if;
  logic       place_req;
  logic [9:0] place_x;
  logic [9:0] place_y;
  logic       place_ack;
  logic       place_nack;
  logic       expl_valid;
  logic [9:0] expl_x;
  logic [9:0] expl_y;
  logic       expl_ready;
  modport master (
    input  place_req, place_x, place_y, expl_ready,
    output place_ack, place_nack, expl_valid, expl_x, expl_y
  );
  modport slave (
    output place_req, place_x, place_y, expl_ready,
    input  place_ack, place_nack, expl_valid, expl_x, expl_y
  );
endinterface

// File: rtl/bomb_manager.sv
// bomb_manager: multi-slot bomb fuses, explosion event FIFO and per-pixel sprite hit detect.
// Optional chain reaction between aligned bombs enabled by defining BOMB_CHAIN_EN.
module bomb_manager #(
  parameter int MAX_BOMBS   = 6,
  parameter int FUSE_CYCLES = 400000000,
  parameter int TIMER_W     = 29,
  parameter int BOMB_W      = 16,
  parameter int BOMB_H      = 16,
  parameter int EVQ_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  bomb_manager_if.master bus,
  input  logic [9:0]     v_x,
  input  logic [9:0]     v_y,
  output logic [4:0]     active_count,
  output logic           bomb_on,
  output logic [3:0]     sprite_col,
  output logic [3:0]     sprite_row
);
  localparam int AW = $clog2(EVQ_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(EVQ_DEPTH);
  typedef enum logic {IDLE, CHECK} state_t;
  state_t state_q, state_d;
  logic req_q, ack_q, ack_d, nack_q, nack_d;
  logic [MAX_BOMBS-1:0] act_q, act_d, push_sel, free_sel;
  logic [9:0] x_q [MAX_BOMBS];
  logic [9:0] x_d [MAX_BOMBS];
  logic [9:0] y_q [MAX_BOMBS];
  logic [9:0] y_d [MAX_BOMBS];
  logic [TIMER_W-1:0] fuse_q [MAX_BOMBS];
  logic [TIMER_W-1:0] fuse_d [MAX_BOMBS];
  logic [9:0] qx_q [EVQ_DEPTH];
  logic [9:0] qx_d [EVQ_DEPTH];
  logic [9:0] qy_q [EVQ_DEPTH];
  logic [9:0] qy_d [EVQ_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [4:0] nact_q, nact_d;
  logic on_q, on_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic pop, push, exp_hit, free_hit, dup;
  logic [9:0] push_x, push_y;
`ifdef BOMB_CHAIN_EN
  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    return {1'b0, (a > b) ? a - b : b - a} <= 11'(3 * BOMB_W);
  endfunction
`endif
  always_comb begin
    state_d = state_q;
    ack_d = 1'b0;
    nack_d = 1'b0;
    act_d = act_q;
    x_d = x_q;
    y_d = y_q;
    fuse_d = fuse_q;
    qx_d = qx_q;
    qy_d = qy_q;
    wp_d = wp_q;
    rp_d = rp_q;
    nact_d = '0;
    on_d = 1'b0;
    col_d = col_q;
    row_d = row_q;
    exp_hit = 1'b0;
    free_hit = 1'b0;
    dup = 1'b0;
    push_sel = '0;
    free_sel = '0;
    push_x = '0;
    push_y = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      nact_d = nact_d + 5'(act_q[i]);
      if (act_q[i] && fuse_q[i] != '0) fuse_d[i] = fuse_q[i] - 1'b1;
      if (!exp_hit && act_q[i] && fuse_q[i] == '0) begin
        exp_hit = 1'b1;
        push_sel[i] = 1'b1;
        push_x = x_q[i];
        push_y = y_q[i];
      end
      if (!free_hit && !act_q[i]) begin
        free_hit = 1'b1;
        free_sel[i] = 1'b1;
      end
      if (act_q[i] && x_q[i] == bus.place_x && y_q[i] == bus.place_y) dup = 1'b1;
      // 11-bit upper bounds so sprites near the right/bottom edge never wrap to 0
      if (!on_d && act_q[i] && v_x >= x_q[i] && v_y >= y_q[i] &&
          {1'b0, v_x} <= {1'b0, x_q[i]} + 11'(BOMB_W - 1) &&
          {1'b0, v_y} <= {1'b0, y_q[i]} + 11'(BOMB_H - 1)) begin
        on_d = 1'b1;
        col_d = 4'(v_x - x_q[i]);
        row_d = 4'(v_y - y_q[i]);
      end
    end
    pop = cnt_q != '0 && bus.expl_ready;
    push = exp_hit && (cnt_q != FULL || pop);
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) begin
      qx_d[wp_q] = push_x;
      qy_d[wp_q] = push_y;
      act_d = act_q & ~push_sel;
    end
`ifdef BOMB_CHAIN_EN
    for (int i = 0; i < MAX_BOMBS; i++)
      if (push && act_q[i] && !push_sel[i] && fuse_d[i] > TIMER_W'(1) &&
          ((x_q[i] == push_x && near(y_q[i], push_y)) || (y_q[i] == push_y && near(x_q[i], push_x))))
        fuse_d[i] = TIMER_W'(1);
`endif
    // Placement sees only the registered slot state, so a slot freed this cycle is not reused yet
    if (state_q == IDLE) begin
      state_d = (bus.place_req && !req_q) ? CHECK : IDLE;
    end else begin
      state_d = IDLE;
      ack_d = !dup && free_hit;
      nack_d = !ack_d;
      for (int i = 0; i < MAX_BOMBS; i++)
        if (ack_d && free_sel[i]) begin
          act_d[i] = 1'b1;
          x_d[i] = bus.place_x;
          y_d[i] = bus.place_y;
          fuse_d[i] = TIMER_W'(FUSE_CYCLES - 1);
        end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      ack_q <= 1'b0;
      nack_q <= 1'b0;
      act_q <= '0;
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      fuse_q <= '{default: '0};
      qx_q <= '{default: '0};
      qy_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      nact_q <= '0;
      on_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= bus.place_req;
      ack_q <= ack_d;
      nack_q <= nack_d;
      act_q <= act_d;
      x_q <= x_d;
      y_q <= y_d;
      fuse_q <= fuse_d;
      qx_q <= qx_d;
      qy_q <= qy_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      nact_q <= nact_d;
      on_q <= on_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  assign bus.place_ack = ack_q;
  assign bus.place_nack = nack_q;
  assign bus.expl_valid = cnt_q != '0;
  assign bus.expl_x = qx_q[rp_q];
  assign bus.expl_y = qy_q[rp_q];
  assign active_count = nact_q;
  assign bomb_on = on_q;
  assign sprite_col = col_q;
  assign sprite_row = row_q;
endmodule

// File: tb/tb_bomb_manager.sv
// tb_bomb_manager: directed scenarios plus random traffic against a queue-based slot model.
module tb_bomb_manager;
  localparam int NB = 6;
  localparam int F = 40;
  localparam int DEPTH = 2;
  localparam int BW = 16;
  localparam int BH = 16;
  logic clk = 0;
  logic reset = 1;
  logic [9:0] v_x = 0;
  logic [9:0] v_y = 0;
  logic [4:0] active_count;
  logic bomb_on;
  logic [3:0] sprite_col, sprite_row;
  int n_chk = 0;
  int n_pass = 0;
  bomb_manager_if bus ();
  bomb_manager #(
    .MAX_BOMBS(NB), .FUSE_CYCLES(F), .TIMER_W(6), .BOMB_W(BW), .BOMB_H(BH), .EVQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .v_x(v_x), .v_y(v_y),
    .active_count(active_count), .bomb_on(bomb_on), .sprite_col(sprite_col), .sprite_row(sprite_row)
  );
  always #5 clk = ~clk;
  // Reference model: slots as plain arrays, event queue as a SystemVerilog queue
  bit m_act [NB];
  int m_x [NB], m_y [NB], m_fuse [NB];
  int qx [$], qy [$];
  bit m_prev, m_pend, m_ack, m_nack, m_on;
  int m_cnt, m_col, m_row;
  int mi_hit, mi_e, mi_f, mi_n, vx, vy, px, py;
  bit mi_dup, mi_pop, mi_push;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_fuse[i] = 0;
      end
      qx.delete(); qy.delete();
      m_prev = 0; m_pend = 0; m_ack = 0; m_nack = 0; m_on = 0;
      m_cnt = 0; m_col = 0; m_row = 0;
    end else begin
      vx = int'(v_x); vy = int'(v_y); px = int'(bus.place_x); py = int'(bus.place_y);
      mi_hit = -1; mi_e = -1; mi_f = -1; mi_n = 0; mi_dup = 0;
      for (int i = 0; i < NB; i++) begin
        if (mi_hit < 0 && m_act[i] && vx >= m_x[i] && vx < m_x[i] + BW && vy >= m_y[i] && vy < m_y[i] + BH) mi_hit = i;
        if (m_act[i]) mi_n++;
        if (mi_e < 0 && m_act[i] && m_fuse[i] == 0) mi_e = i;
        if (mi_f < 0 && !m_act[i]) mi_f = i;
        if (m_act[i] && m_x[i] == px && m_y[i] == py) mi_dup = 1;
      end
      m_on = mi_hit >= 0;
      if (m_on) begin
        m_col = (vx - m_x[mi_hit]) % 16;
        m_row = (vy - m_y[mi_hit]) % 16;
      end
      m_cnt = mi_n;
      mi_pop = qx.size() > 0 && bus.expl_ready;
      mi_push = mi_e >= 0 && (qx.size() < DEPTH || mi_pop);
      if (mi_pop) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
      for (int i = 0; i < NB; i++) if (m_act[i] && m_fuse[i] > 0) m_fuse[i]--;
      if (mi_push) begin
        qx.push_back(m_x[mi_e]);
        qy.push_back(m_y[mi_e]);
        m_act[mi_e] = 0;
`ifdef BOMB_CHAIN_EN
        for (int i = 0; i < NB; i++)
          if (m_act[i] && m_fuse[i] > 1 &&
              ((m_x[i] == m_x[mi_e] && (m_y[i] - m_y[mi_e] <= 3*BW) && (m_y[mi_e] - m_y[i] <= 3*BW)) ||
               (m_y[i] == m_y[mi_e] && (m_x[i] - m_x[mi_e] <= 3*BW) && (m_x[mi_e] - m_x[i] <= 3*BW))))
            m_fuse[i] = 1;
`endif
      end
      m_ack = m_pend && !mi_dup && mi_f >= 0;
      m_nack = m_pend && !m_ack;
      if (m_ack) begin
        m_act[mi_f] = 1; m_x[mi_f] = px; m_y[mi_f] = py; m_fuse[mi_f] = F - 1;
      end
      m_pend = !m_pend && bus.place_req && !m_prev;
      m_prev = bus.place_req;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic place(input int x, input int y, output bit a, output bit n);
    bus.place_req = 1; bus.place_x = 10'(x); bus.place_y = 10'(y);
    tick; tick;
    a = bus.place_ack; n = bus.place_nack;
    bus.place_req = 0;
    tick;
  endtask
  task automatic drain(input int cycles);
    bus.expl_ready = 1;
    repeat (cycles) tick;
    bus.expl_ready = 0;
  endtask
  task automatic test_reset;
    repeat (3) tick;
    reset = 0;
    tick;
    n_chk++; if (bus.place_ack !== 1'b0) $display("FAIL reset_ack got %0b want 0", bus.place_ack); else n_pass++;
    n_chk++; if (bus.place_nack !== 1'b0) $display("FAIL reset_nack got %0b want 0", bus.place_nack); else n_pass++;
    n_chk++; if (active_count !== 5'd0) $display("FAIL reset_count got %0d want 0", active_count); else n_pass++;
    n_chk++; if (bus.expl_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.expl_valid); else n_pass++;
    n_chk++; if (bomb_on !== 1'b0) $display("FAIL reset_on got %0b want 0", bomb_on); else n_pass++;
    n_chk++; if ({sprite_col, sprite_row} !== 8'd0) $display("FAIL reset_colrow got %0h want 0", {sprite_col, sprite_row}); else n_pass++;
  endtask
  task automatic test_single;
    bit a, n;
    int k;
    place(32, 48, a, n);
    n_chk++; if ({a, n} !== 2'b10) $display("FAIL single_ack got ack=%0b nack=%0b want 1/0", a, n); else n_pass++;
    n_chk++; if (active_count !== 5'd1) $display("FAIL single_count got %0d want 1", active_count); else n_pass++;
    k = 1;
    while (!bus.expl_valid && k < 80) begin tick; k++; end
    n_chk++; if (k !== F) $display("FAIL single_expiry got %0d cycles want %0d", k, F); else n_pass++;
    n_chk++; if ({bus.expl_x, bus.expl_y} !== {10'd32, 10'd48}) $display("FAIL single_xy got (%0d,%0d) want (32,48)", bus.expl_x, bus.expl_y); else n_pass++;
    n_chk++; if (active_count !== 5'd1) $display("FAIL single_count_lag got %0d want 1", active_count); else n_pass++;
    bus.expl_ready = 1;
    tick;
    bus.expl_ready = 0;
    n_chk++; if (bus.expl_valid !== 1'b0) $display("FAIL single_pop got %0b want 0", bus.expl_valid); else n_pass++;
    n_chk++; if (active_count !== 5'd0) $display("FAIL single_count_end got %0d want 0", active_count); else n_pass++;
  endtask
  task automatic test_full;
    bit a, n;
    int got [6];
    int cnt;
    for (int i = 0; i < 6; i++) begin
      place(i*32 + 16, 100, a, n);
      n_chk++; if ({a, n} !== 2'b10) $display("FAIL full_ack%0d got ack=%0b nack=%0b want 1/0", i, a, n); else n_pass++;
    end
    place(300, 300, a, n);
    n_chk++; if ({a, n} !== 2'b01) $display("FAIL full_nack got ack=%0b nack=%0b want 0/1", a, n); else n_pass++;
    tick;
    n_chk++; if (active_count !== 5'd6) $display("FAIL full_count got %0d want 6", active_count); else n_pass++;
    repeat (70) tick;
    n_chk++; if (active_count !== 5'd4) $display("FAIL full_blocked got %0d want 4", active_count); else n_pass++;
    n_chk++; if ({bus.expl_valid, bus.expl_x} !== {1'b1, 10'd16}) $display("FAIL full_head got v=%0b x=%0d want v=1 x=16", bus.expl_valid, bus.expl_x); else n_pass++;
    bus.expl_ready = 1;
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 6; k++) begin
      if (bus.expl_valid) begin got[cnt] = int'(bus.expl_x); cnt++; end
      tick;
    end
    bus.expl_ready = 0;
    n_chk++; if (cnt !== 6) $display("FAIL full_drain got %0d events want 6", cnt); else n_pass++;
    for (int i = 0; i < cnt; i++) begin
      n_chk++; if (got[i] !== i*32 + 16) $display("FAIL full_order%0d got x=%0d want %0d", i, got[i], i*32 + 16); else n_pass++;
    end
    tick;
    n_chk++; if (active_count !== 5'd0) $display("FAIL full_empty got %0d want 0", active_count); else n_pass++;
  endtask
  task automatic test_dup;
    bit a, n;
    int acks;
    place(64, 64, a, n);
    n_chk++; if ({a, n} !== 2'b10) $display("FAIL dup_first got ack=%0b nack=%0b want 1/0", a, n); else n_pass++;
    place(64, 64, a, n);
    n_chk++; if ({a, n} !== 2'b01) $display("FAIL dup_second got ack=%0b nack=%0b want 0/1", a, n); else n_pass++;
    tick;
    n_chk++; if (active_count !== 5'd1) $display("FAIL dup_count got %0d want 1", active_count); else n_pass++;
    bus.place_req = 1; bus.place_x = 200; bus.place_y = 64;
    acks = 0;
    repeat (8) begin tick; if (bus.place_ack) acks++; end
    bus.place_req = 0;
    tick;
    n_chk++; if (acks !== 1) $display("FAIL dup_held got %0d acks want 1", acks); else n_pass++;
    n_chk++; if (active_count !== 5'd2) $display("FAIL dup_held_count got %0d want 2", active_count); else n_pass++;
    drain(60);
  endtask
  task automatic test_hit;
    bit a, n;
    place(100, 200, a, n);
    place(1015, 0, a, n);
    v_x = 115; v_y = 215; tick;
    n_chk++; if ({bomb_on, sprite_col, sprite_row} !== {1'b1, 4'd15, 4'd15}) $display("FAIL hit_corner got on=%0b col=%0d row=%0d want 1/15/15", bomb_on, sprite_col, sprite_row); else n_pass++;
    v_x = 116; tick;
    n_chk++; if ({bomb_on, sprite_col, sprite_row} !== {1'b0, 4'd15, 4'd15}) $display("FAIL hit_right got on=%0b col=%0d row=%0d want 0/15/15", bomb_on, sprite_col, sprite_row); else n_pass++;
    v_x = 100; v_y = 200; tick;
    n_chk++; if ({bomb_on, sprite_col, sprite_row} !== {1'b1, 4'd0, 4'd0}) $display("FAIL hit_origin got on=%0b col=%0d row=%0d want 1/0/0", bomb_on, sprite_col, sprite_row); else n_pass++;
    v_y = 216; tick;
    n_chk++; if (bomb_on !== 1'b0) $display("FAIL hit_below got %0b want 0", bomb_on); else n_pass++;
    v_x = 1020; v_y = 5; tick;
    n_chk++; if ({bomb_on, sprite_col, sprite_row} !== {1'b1, 4'd5, 4'd5}) $display("FAIL hit_edge got on=%0b col=%0d row=%0d want 1/5/5", bomb_on, sprite_col, sprite_row); else n_pass++;
    v_x = 3; tick;
    n_chk++; if (bomb_on !== 1'b0) $display("FAIL hit_nowrap got %0b want 0", bomb_on); else n_pass++;
    drain(60);
  endtask
`ifdef BOMB_CHAIN_EN
  task automatic test_chain;
    bit a, n;
    int k;
    place(32, 32, a, n);
    repeat (20) tick;
    place(64, 32, a, n);
    bus.expl_ready = 1;
    k = 0;
    while (!bus.expl_valid && k < 80) begin tick; k++; end
    n_chk++; if ({bus.expl_valid, bus.expl_x} !== {1'b1, 10'd32}) $display("FAIL chain_first got v=%0b x=%0d want 1/32", bus.expl_valid, bus.expl_x); else n_pass++;
    k = 0;
    do begin tick; k++; end while (!(bus.expl_valid && bus.expl_x == 10'd64) && k < 20);
    n_chk++; if (k > 3) $display("FAIL chain_second got %0d cycles want <=3", k); else n_pass++;
    drain(10);
  endtask
`endif
  task automatic test_reset_mid;
    bit a, n;
    place(500, 500, a, n);
    bus.place_req = 1; bus.place_x = 600; bus.place_y = 600;
    tick;
    reset = 1; bus.place_req = 0;
    #2;
    n_chk++; if (active_count !== 5'd0) $display("FAIL mid_async_count got %0d want 0", active_count); else n_pass++;
    tick;
    reset = 0;
    tick; tick;
    n_chk++; if ({bus.place_ack, bus.place_nack} !== 2'b00) $display("FAIL mid_no_result got ack=%0b nack=%0b want 0/0", bus.place_ack, bus.place_nack); else n_pass++;
    v_x = 505; v_y = 505; tick;
    n_chk++; if ({bomb_on, active_count} !== 6'd0) $display("FAIL mid_cleared got on=%0b cnt=%0d want 0/0", bomb_on, active_count); else n_pass++;
  endtask
  task automatic test_random;
    int s;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.place_req = !bus.place_req;
        if (bus.place_req) begin
          bus.place_x = ($urandom_range(0, 9) == 0) ? 10'(1010 + $urandom_range(0, 13)) : 10'($urandom_range(0, 7) * 8);
          bus.place_y = 10'($urandom_range(0, 3) * 16);
        end
      end
      bus.expl_ready = 1'($urandom_range(0, 1));
      s = $urandom_range(0, NB - 1);
      v_x = 10'(m_x[s] + int'($urandom_range(0, 19)) - 2);
      v_y = 10'(m_y[s] + int'($urandom_range(0, 19)) - 2);
      tick;
      n_chk++; if (bus.place_ack !== m_ack) $display("FAIL rand_ack c=%0d got %0b want %0b", c, bus.place_ack, m_ack); else n_pass++;
      n_chk++; if (bus.place_nack !== m_nack) $display("FAIL rand_nack c=%0d got %0b want %0b", c, bus.place_nack, m_nack); else n_pass++;
      n_chk++; if (active_count !== 5'(m_cnt)) $display("FAIL rand_count c=%0d got %0d want %0d", c, active_count, m_cnt); else n_pass++;
      n_chk++; if (bomb_on !== m_on) $display("FAIL rand_on c=%0d got %0b want %0b", c, bomb_on, m_on); else n_pass++;
      n_chk++; if ({sprite_col, sprite_row} !== {4'(m_col), 4'(m_row)}) $display("FAIL rand_colrow c=%0d got %0d/%0d want %0d/%0d", c, sprite_col, sprite_row, m_col, m_row); else n_pass++;
      n_chk++; if (bus.expl_valid !== (qx.size() > 0)) $display("FAIL rand_valid c=%0d got %0b want %0b", c, bus.expl_valid, qx.size() > 0); else n_pass++;
      if (qx.size() > 0) begin
        n_chk++; if ({bus.expl_x, bus.expl_y} !== {10'(qx[0]), 10'(qy[0])}) $display("FAIL rand_xy c=%0d got (%0d,%0d) want (%0d,%0d)", c, bus.expl_x, bus.expl_y, qx[0], qy[0]); else n_pass++;
      end
    end
    bus.place_req = 0;
    drain(80);
    n_chk++; if ({bus.expl_valid, active_count} !== 6'd0) $display("FAIL rand_final got v=%0b cnt=%0d want 0/0", bus.expl_valid, active_count); else n_pass++;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    bus.place_req = 0; bus.place_x = 0; bus.place_y = 0; bus.expl_ready = 0;
    test_reset;
    test_single;
    test_full;
    test_dup;
    test_hit;
`ifdef BOMB_CHAIN_EN
    test_chain;
`endif
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
